// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus: req/gnt/rvalid handshake between fetch (master) and memory (slave).
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC register, single outstanding imem read, hand-off to decode.
// Optional misaligned-next-PC trap enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   next_pc,
    input  logic          next_pc_valid,
    fetch_unit_if.master  imem,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    input  logic          inst_ready,
    output logic [31:0]   fetch_count,
    output logic          fetch_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        NEXT  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        capture;
    logic        count_en;
    logic        take_pc;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        count_en  = 1'b0;
        take_pc   = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem.gnt && imem.rvalid) begin
                    capture   = 1'b1;
                    state_nxt = VALID;
                end else if (imem.gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    capture   = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (inst_ready) begin
                    count_en  = 1'b1;
                    state_nxt = NEXT;
                    take_pc   = next_pc_valid;
                end
            end
            NEXT:    take_pc = next_pc_valid;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase

        if (take_pc) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (next_pc[1:0] != 2'b00) begin
                state_nxt = ERR;
            end else begin
                pc_nxt    = next_pc;
                state_nxt = REQ;
            end
`else
            pc_nxt    = next_pc & 32'hFFFF_FFFC;
            state_nxt = REQ;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inst        <= '0;
            inst_pc     <= '0;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                inst    <= imem.rdata;
                inst_pc <= pc;
            end
            if (count_en) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign imem.req   = (state == REQ);
    assign imem.addr  = pc;
    assign inst_valid = (state == VALID);

`ifdef FETCH_MISALIGN_CHK_EN
    assign fetch_err = (state == ERR);
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected {pc, word} pairs checked at hand-off.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        next_pc_valid;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] fetch_count;
    logic        fetch_err;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_pc       (next_pc),
        .next_pc_valid (next_pc_valid),
        .imem          (bus),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .fetch_count   (fetch_count),
        .fetch_err     (fetch_err)
    );

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count;
    logic [31:0] exp_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h00A0_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Zero-wait memory response; the expected entry uses the bench's own PC model.
    task automatic respond(input logic [31:0] pc);
        bus.gnt    = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = mem_word(bus.addr);
        sb.push_back('{pc, mem_word(pc)});
        @(negedge clk);
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_pc = '0; next_pc_valid = 1'b0; inst_ready = 1'b0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        exp_count = '0;
        exp_pc = RST_PC;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.req); end
        n_checks++; if (bus.addr !== RST_PC) begin n_fail++; $display("FAIL rst_addr: got %h want %h", bus.addr, RST_PC); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        n_checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h/%h want 0/0", inst, inst_pc); end
        n_checks++; if (fetch_count !== 32'h0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_err: got %h/%b want 0/0", fetch_count, fetch_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        exp_t e;
        @(negedge clk);
        n_checks++; if (bus.req !== 1'b1 || bus.addr !== RST_PC) begin n_fail++; $display("FAIL zw_first_req: got %b/%h want 1/%h", bus.req, bus.addr, RST_PC); end
        respond(exp_pc);
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid: got %b want 1", inst_valid); end
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL zw_sb: got empty want entry"); end
        else begin
            e = sb.pop_front();
            if (inst !== e.word || inst_pc !== e.pc) begin n_fail++; $display("FAIL zw_inst: got %h@%h want %h@%h", inst, inst_pc, e.word, e.pc); end
        end
        inst_ready = 1'b1; next_pc_valid = 1'b1; next_pc = 32'h1F4;
        exp_count++; exp_pc = 32'h1F4;
        @(negedge clk);
        inst_ready = 1'b0; next_pc_valid = 1'b0;
        n_checks++; if (bus.req !== 1'b1 || bus.addr !== exp_pc) begin n_fail++; $display("FAIL zw_redirect: got %b/%h want 1/%h", bus.req, bus.addr, exp_pc); end
        n_checks++; if (fetch_count !== exp_count || inst_valid !== 1'b0) begin n_fail++; $display("FAIL zw_count: got %h/%b want %h/0", fetch_count, inst_valid, exp_count); end
    endtask

    task automatic test_wait_states();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.req !== 1'b1 || bus.addr !== exp_pc) begin n_fail++; $display("FAIL ws_stable%0d: got %b/%h want 1/%h", i, bus.req, bus.addr, exp_pc); end
            @(negedge clk);
        end
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL ws_wait_req: got %b want 0", bus.req); end
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL ws_early_valid: got %b want 0", inst_valid); end
        bus.rvalid = 1'b1; bus.rdata = mem_word(exp_pc);
        sb.push_back('{exp_pc, mem_word(exp_pc)});
        @(negedge clk);
        bus.rvalid = 1'b0; bus.rdata = '0;
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL ws_sb: got empty want entry"); end
        else begin
            e = sb.pop_front();
            if (inst_valid !== 1'b1 || inst !== e.word || inst_pc !== e.pc) begin
                n_fail++; $display("FAIL ws_inst: got v=%b %h@%h want v=1 %h@%h", inst_valid, inst, inst_pc, e.word, e.pc);
            end
        end
        inst_ready = 1'b1;
        exp_count++;
        @(negedge clk);
        inst_ready = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || bus.req !== 1'b0 || fetch_count !== exp_count) begin
            n_fail++; $display("FAIL ws_next: got v=%b req=%b cnt=%h want 0/0/%h", inst_valid, bus.req, fetch_count, exp_count);
        end
        next_pc_valid = 1'b1; next_pc = 32'h200; exp_pc = 32'h200;
        @(negedge clk);
        next_pc_valid = 1'b0;
        n_checks++; if (bus.req !== 1'b1 || bus.addr !== exp_pc) begin n_fail++; $display("FAIL ws_next_req: got %b/%h want 1/%h", bus.req, bus.addr, exp_pc); end
    endtask

    task automatic test_stall();
        exp_t e;
        respond(exp_pc);
        e = '{32'h0, 32'h0};
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL st_sb: got empty want entry"); end
        else e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (inst_valid !== 1'b1 || inst !== e.word || inst_pc !== e.pc || fetch_count !== exp_count) begin
                n_fail++; $display("FAIL st_hold%0d: got v=%b %h@%h cnt=%h want 1 %h@%h cnt=%h", i, inst_valid, inst, inst_pc, fetch_count, e.word, e.pc, exp_count);
            end
            next_pc_valid = i[0]; next_pc = 32'h300;
            bus.rvalid = ~i[0]; bus.rdata = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        bus.rvalid = 1'b0; bus.rdata = '0;
        n_checks++; if (inst !== e.word || fetch_count !== exp_count) begin n_fail++; $display("FAIL st_final: got %h cnt=%h want %h cnt=%h", inst, fetch_count, e.word, exp_count); end
        inst_ready = 1'b1; next_pc_valid = 1'b1; next_pc = 32'h240;
        exp_count++; exp_pc = 32'h240;
        @(negedge clk);
        inst_ready = 1'b0; next_pc_valid = 1'b0;
        n_checks++; if (bus.addr !== exp_pc || fetch_count !== exp_count) begin n_fail++; $display("FAIL st_resume: got %h cnt=%h want %h cnt=%h", bus.addr, fetch_count, exp_pc, exp_count); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] np;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (bus.req !== 1'b1 || bus.addr !== exp_pc) begin n_fail++; $display("FAIL b2b_req%0d: got %b/%h want 1/%h", i, bus.req, bus.addr, exp_pc); end
            respond(exp_pc);
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_sb%0d: got empty want entry", i); end
            else begin
                e = sb.pop_front();
                if (inst_valid !== 1'b1 || inst !== e.word || inst_pc !== e.pc) begin
                    n_fail++; $display("FAIL b2b_inst%0d: got v=%b %h@%h want 1 %h@%h", i, inst_valid, inst, inst_pc, e.word, e.pc);
                end
            end
            np = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
            inst_ready = 1'b1; next_pc_valid = 1'b1; next_pc = np;
            exp_count++; exp_pc = np;
            @(negedge clk);
            inst_ready = 1'b0; next_pc_valid = 1'b0;
        end
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL b2b_count: got %h want %h", fetch_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        n_checks++; if (bus.req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rm_wait: got req=%b v=%b want 0/0", bus.req, inst_valid); end
        #2 rst_n = 1'b0;
        #1;
        exp_count = '0;
        exp_pc = RST_PC;
        sb.delete();
        n_checks++; if (bus.req !== 1'b0 || bus.addr !== RST_PC || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || fetch_count !== 32'h0 || fetch_err !== 1'b0) begin
            n_fail++; $display("FAIL rm_clear: got req=%b addr=%h v=%b inst=%h pc=%h cnt=%h err=%b want all reset values",
                               bus.req, bus.addr, inst_valid, inst, inst_pc, fetch_count, fetch_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.rvalid = 1'b1; bus.rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.rvalid = 1'b0; bus.rdata = '0;
        n_checks++; if (bus.req !== 1'b1 || bus.addr !== RST_PC || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm_refetch: got req=%b addr=%h v=%b want 1/%h/0", bus.req, bus.addr, inst_valid, RST_PC);
        end
        respond(exp_pc);
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rm_sb: got empty want entry"); end
        else begin
            e = sb.pop_front();
            if (inst_valid !== 1'b1 || inst !== e.word || inst_pc !== e.pc) begin
                n_fail++; $display("FAIL rm_inst: got v=%b %h@%h want 1 %h@%h", inst_valid, inst, inst_pc, e.word, e.pc);
            end
        end
    endtask

    task automatic test_misalign();
        // Entered in VALID holding the RESET_PC instruction.
        inst_ready = 1'b1; next_pc_valid = 1'b1; next_pc = 32'h102;
        exp_count++;
        @(negedge clk);
        inst_ready = 1'b0; next_pc_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (fetch_err !== 1'b1 || bus.req !== 1'b0 || inst_valid !== 1'b0) begin
                n_fail++; $display("FAIL ma_err%0d: got err=%b req=%b v=%b want 1/0/0", i, fetch_err, bus.req, inst_valid);
            end
            next_pc_valid = 1'b1; next_pc = 32'h400;
            @(negedge clk);
        end
        next_pc_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL ma_clear: got %b want 0", fetch_err); end
`else
        n_checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h100 || fetch_err !== 1'b0) begin
            n_fail++; $display("FAIL ma_align: got req=%b addr=%h err=%b want 1/00000100/0", bus.req, bus.addr, fetch_err);
        end
        n_checks++; if (fetch_count !== exp_count) begin n_fail++; $display("FAIL ma_count: got %h want %h", fetch_count, exp_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
